storage_router: RTL and testbench
=================================

Name: storage_router

Overview:
- Parametrised successor to the single-word storage controller.
- Accepts one outstanding word request from the vector core over a valid/ready handshake and decodes the address into an on-chip SRAM scratchpad window or a read-only external QSPI window.
- QSPI reads go through a single-line read buffer. A miss fills LINE_WORDS consecutive words; hits return in one cycle.
- Sits between the core memory port and the SRAM macro / qspi_controller. Programming mode locks out all core traffic.

Parameters:
- MEM_W, 32, data bus width in bits.
- MEM_SZ, 262144, external storage size in bytes.
- SRAM_BASE, 32'h0000_0000, byte base of the SRAM window.
- SRAM_WORDS, 2048, SRAM depth in words. Power of two.
- EXT_BASE, 32'h0001_0000, byte base of the external window, which is MEM_SZ bytes long.
- LINE_WORDS, 4, words per read-buffer line. Power of two, at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both valid and ready are high.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address. Bits [log2(MEM_W/8)-1:0] are ignored.
- req_wdata  in  MEM_W  write data.
- req_be  in  MEM_W/8  byte enables, active-high.
- rsp_valid  out  1  single-cycle response pulse. No backpressure.
- rsp_rdata  out  MEM_W  read data. 0 on writes and errors.
- rsp_err  out  1  qualifies rsp_valid. Set for an unmapped address or a write to the external window.
- prog_mode  in  1  programming mode request.
- prog_active  out  1  block is in the PROG state.
- sram_cen_n  out  1  SRAM chip enable, active-low.
- sram_gwen_n  out  1  SRAM global write enable, active-low.
- sram_wen_n  out  MEM_W/8  SRAM byte write enables, active-low.
- sram_addr  out  log2(SRAM_WORDS)  SRAM word address.
- sram_d  out  MEM_W  SRAM write data.
- sram_q  in  MEM_W  SRAM read data, valid one cycle after the access.
- ext_req  out  1  QSPI word read request. Held until ext_ack.
- ext_addr  out  log2(MEM_SZ)-log2(MEM_W/8)  QSPI word index.
- ext_ack  in  1  ext_rdata valid. Single-cycle pulse.
- ext_rdata  in  MEM_W  QSPI read word.

Behaviour:
- Reset (rst low, asynchronous):
  - State is IDLE; line buffer valid = 0.
  - req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, prog_active=0, ext_req=0, ext_addr=0.
  - SRAM outputs idle: cen_n=1, gwen_n=1, wen_n=all 1, addr=0, d=0.
- Address decode is combinational on req_addr:
  - SRAM hit when SRAM_BASE <= addr < SRAM_BASE + 4*SRAM_WORDS.
  - EXT hit when EXT_BASE <= addr < EXT_BASE + MEM_SZ.
  - Anything else is unmapped.
  - Word index is (addr - base) >> log2(MEM_W/8).
- req_ready = (state == IDLE) && !prog_mode.
- States and transitions:
  - IDLE:
    - prog_mode=1 -> PROG.
    - Accepted SRAM request: drive the SRAM pins in the acceptance cycle, with cen_n=0, gwen_n=!req_write, wen_n=~req_be -> SRAM_RSP.
    - Accepted EXT read on a line-buffer hit (valid && tag match) -> HIT_RSP.
    - Accepted EXT read on a miss -> FILL.
    - Accepted EXT write or unmapped address -> ERR_RSP.
  - SRAM_RSP: rsp_valid=1. rsp_rdata = sram_q on a read, 0 on a write -> IDLE. Total latency is 1 cycle.
  - HIT_RSP: rsp_valid=1, rsp_rdata = the buffered word -> IDLE. Latency 1 cycle.
  - ERR_RSP: rsp_valid=1, rsp_err=1, rsp_rdata=0 -> IDLE. No SRAM or QSPI activity.
  - FILL:
    - On entry, clear valid, latch the tag, and clear the beat counter.
    - ext_addr = line base index + beat. ext_req is held high through each ext_ack.
    - Each ack writes the buffer entry [beat] and increments beat.
    - On the ack where beat = LINE_WORDS-1: set valid -> HIT_RSP.
    - The line base index clears the low log2(LINE_WORDS) bits. A line never straddles the end of the window, because MEM_SZ is a multiple of the line size.
  - PROG: prog_active=1, req_ready=0, line buffer valid cleared. prog_mode=0 -> IDLE.
- prog_mode is sampled only in IDLE. An in-flight FILL or response completes normally first.
- The request is latched at acceptance. req_* values may change afterwards with no effect.
- Outside SRAM access cycles the SRAM pins return to their idle values.
- Any assertion of rst mid-FILL drops ext_req immediately and discards the partial line.

Decomposition:
- Package storage_router_pkg holds:
  - the state enum (IDLE, SRAM_RSP, HIT_RSP, ERR_RSP, FILL, PROG);
  - a region enum (REG_SRAM, REG_EXT, REG_NONE);
  - derived width localparams (BYTE_OFF_W, SRAM_AW, EXT_AW, LINE_OFF_W).
- One sub-module, storage_line_buffer: tag register, valid bit, LINE_WORDS x MEM_W storage, fill-write port, hit/read port, and invalidate input.
- The decoder and FSM stay in the top module.

Test Plan:
- SRAM write, then read: write addr 0x10 data 0xDEADBEEF be=4'b0101 over prior content 0, then read 0x10. Both complete with rsp_valid one cycle after acceptance; the read returns 0x00AD00EF, err=0.
- EXT miss then hit (ext model acks after 3 cycles, data = word index):
  - Read 0x0001_0024 issues ext_addr 8, 9, 10, 11 and returns 9.
  - A following read of 0x0001_0028 returns 10 after 1 cycle with no ext_req.
- Error cases, each giving rsp_err=1 and rsp_rdata=0 after 1 cycle, with ext_req and cen_n never asserted:
  - write to 0x0001_0000;
  - read of 0x0000_9000.
- Programming mode: assert prog_mode during a FILL. The fill completes and responds, then prog_active=1 and req_ready=0. After prog_mode drops, a re-read of the same line misses and refetches.
- Async reset: pull rst low between two acks in a FILL. ext_req drops with no clock edge. After release, a read of the same address performs a full LINE_WORDS refill.
- Back-to-back: hold req_valid high with 8 alternating SRAM/EXT-hit reads. Verify req_ready has one idle cycle per request, responses arrive in order, and each rsp_valid is exactly one cycle wide.

Source files
------------

// File: rtl/storage_router_pkg.sv
// Shared types and default sizing for the storage router and its line buffer.
// Widths below follow the default parameter set; the top re-derives its own from its parameters.
package storage_router_pkg;

    localparam int          DEF_MEM_W      = 32;
    localparam int          DEF_MEM_SZ     = 262144;
    localparam logic [31:0] DEF_SRAM_BASE  = 32'h0000_0000;
    localparam int          DEF_SRAM_WORDS = 2048;
    localparam logic [31:0] DEF_EXT_BASE   = 32'h0001_0000;
    localparam int          DEF_LINE_WORDS = 4;

    localparam int BYTE_OFF_W = $clog2(DEF_MEM_W / 8);
    localparam int SRAM_AW    = $clog2(DEF_SRAM_WORDS);
    localparam int EXT_AW     = $clog2(DEF_MEM_SZ) - BYTE_OFF_W;
    localparam int LINE_OFF_W = $clog2(DEF_LINE_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        SRAM_RSP,
        HIT_RSP,
        ERR_RSP,
        FILL,
        PROG
    } state_e;

    typedef enum logic [1:0] {
        REG_SRAM,
        REG_EXT,
        REG_NONE
    } region_e;

    // Index width that stays at least one bit wide for single-word lines.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/storage_line_buffer.sv
// Single-line read buffer for the external window: tag, valid bit and LINE_WORDS data words.
// A fill start clears valid and captures the tag; invalidate wins over set-valid.
module storage_line_buffer #(
    parameter int MEM_W      = 32,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 14,
    parameter int IDX_W      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inval_i,
    input  logic             fill_start_i,
    input  logic [TAG_W-1:0] fill_tag_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [MEM_W-1:0] wr_data_i,
    input  logic             set_valid_i,
    input  logic [TAG_W-1:0] lookup_tag_i,
    output logic             hit_o,
    output logic [TAG_W-1:0] tag_o,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [MEM_W-1:0] rd_data_o
);

    logic             valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [MEM_W-1:0] data_q [LINE_WORDS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
        end else begin
            if (fill_start_i) begin
                valid_q <= 1'b0;
                tag_q   <= fill_tag_i;
            end else if (set_valid_i) begin
                valid_q <= 1'b1;
            end
            if (inval_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    // Data words need no reset: they are only ever read behind a valid tag match.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign hit_o     = valid_q && (tag_q == lookup_tag_i);
    assign tag_o     = tag_q;
    assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/storage_router.sv
// Routes single word requests from the core to the SRAM scratchpad or the read-only QSPI window,
// with a one-line read buffer in front of QSPI and a programming-mode lockout.
module storage_router
    import storage_router_pkg::*;
#(
    parameter int          MEM_W      = DEF_MEM_W,
    parameter int          MEM_SZ     = DEF_MEM_SZ,
    parameter logic [31:0] SRAM_BASE  = DEF_SRAM_BASE,
    parameter int          SRAM_WORDS = DEF_SRAM_WORDS,
    parameter logic [31:0] EXT_BASE   = DEF_EXT_BASE,
    parameter int          LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        req_valid,
    output logic                                        req_ready,
    input  logic                                        req_write,
    input  logic [31:0]                                 req_addr,
    input  logic [MEM_W-1:0]                            req_wdata,
    input  logic [MEM_W/8-1:0]                          req_be,
    output logic                                        rsp_valid,
    output logic [MEM_W-1:0]                            rsp_rdata,
    output logic                                        rsp_err,
    input  logic                                        prog_mode,
    output logic                                        prog_active,
    output logic                                        sram_cen_n,
    output logic                                        sram_gwen_n,
    output logic [MEM_W/8-1:0]                          sram_wen_n,
    output logic [$clog2(SRAM_WORDS)-1:0]               sram_addr,
    output logic [MEM_W-1:0]                            sram_d,
    input  logic [MEM_W-1:0]                            sram_q,
    output logic                                        ext_req,
    output logic [$clog2(MEM_SZ)-$clog2(MEM_W/8)-1:0]   ext_addr,
    input  logic                                        ext_ack,
    input  logic [MEM_W-1:0]                            ext_rdata
);

    localparam int          BytesPerWord = MEM_W / 8;
    localparam int          ByteOffW     = $clog2(BytesPerWord);
    localparam int          SramAw       = $clog2(SRAM_WORDS);
    localparam int          ExtAw        = $clog2(MEM_SZ) - ByteOffW;
    localparam int          LineOffW     = $clog2(LINE_WORDS);
    localparam int          IdxW         = idxWidth(LINE_WORDS);
    localparam int          TagW         = ExtAw - LineOffW;
    localparam logic [32:0] SramBytes    = 33'(SRAM_WORDS * BytesPerWord);
    localparam logic [32:0] ExtBytes     = 33'(MEM_SZ);
    localparam logic [IdxW-1:0] LastBeat = IdxW'(LINE_WORDS - 1);

    logic [32:0]       sramOff;
    logic [32:0]       extOff;
    region_e           region;
    logic [SramAw-1:0] sramIdx;
    logic [ExtAw-1:0]  extIdx;
    logic [TagW-1:0]   extTag;
    logic [IdxW-1:0]   extLineOff;
    logic              unusedAddrBits;

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [IdxW-1:0]   off_q, off_d;
    logic [IdxW-1:0]   beat_q, beat_d;

    logic              bufHit;
    logic              bufInval;
    logic              bufFillStart;
    logic              bufWrEn;
    logic              bufSetValid;
    logic [TagW-1:0]   bufTag;
    logic [MEM_W-1:0]  bufRdata;

    // 33-bit offsets: an address below a window base underflows into bit 32 and fails the size test.
    assign sramOff = {1'b0, req_addr} - {1'b0, SRAM_BASE};
    assign extOff  = {1'b0, req_addr} - {1'b0, EXT_BASE};

    always_comb begin
        region = REG_NONE;
        if (sramOff < SramBytes) begin
            region = REG_SRAM;
        end else if (extOff < ExtBytes) begin
            region = REG_EXT;
        end
    end

    assign sramIdx        = sramOff[ByteOffW +: SramAw];
    assign extIdx         = extOff[ByteOffW +: ExtAw];
    assign extTag         = TagW'(extIdx >> LineOffW);
    assign extLineOff     = IdxW'(extIdx & ExtAw'(LINE_WORDS - 1));
    assign unusedAddrBits = ^{sramOff, extOff};

    // Ready is also held low while reset is asserted, so nothing is accepted during reset.
    assign req_ready = rst && (state_q == IDLE) && !prog_mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            off_q   <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            off_q   <= off_d;
            beat_q  <= beat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        off_d        = off_q;
        beat_d       = beat_q;
        bufInval     = 1'b0;
        bufFillStart = 1'b0;
        bufWrEn      = 1'b0;
        bufSetValid  = 1'b0;
        rsp_valid    = 1'b0;
        rsp_rdata    = '0;
        rsp_err      = 1'b0;
        prog_active  = 1'b0;
        ext_req      = 1'b0;
        ext_addr     = '0;
        sram_cen_n   = 1'b1;
        sram_gwen_n  = 1'b1;
        sram_wen_n   = '1;
        sram_addr    = '0;
        sram_d       = '0;

        case (state_q)
            IDLE: begin
                if (prog_mode) begin
                    state_d = PROG;
                end else if (req_valid && req_ready) begin
                    write_d = req_write;
                    case (region)
                        REG_SRAM: begin
                            sram_cen_n  = 1'b0;
                            sram_gwen_n = !req_write;
                            sram_wen_n  = ~req_be;
                            sram_addr   = sramIdx;
                            sram_d      = req_wdata;
                            state_d     = SRAM_RSP;
                        end
                        REG_EXT: begin
                            off_d = extLineOff;
                            if (req_write) begin
                                state_d = ERR_RSP;
                            end else if (bufHit) begin
                                state_d = HIT_RSP;
                            end else begin
                                bufFillStart = 1'b1;
                                beat_d       = '0;
                                state_d      = FILL;
                            end
                        end
                        default: state_d = ERR_RSP;
                    endcase
                end
            end

            SRAM_RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = write_q ? '0 : sram_q;
                state_d   = IDLE;
            end

            HIT_RSP: begin
                rsp_valid = 1'b1;
                rsp_rdata = bufRdata;
                state_d   = IDLE;
            end

            ERR_RSP: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                state_d   = IDLE;
            end

            // The requested word is served from the buffer once the whole line has landed.
            FILL: begin
                ext_req  = 1'b1;
                ext_addr = (ExtAw'(bufTag) << LineOffW) | ExtAw'(beat_q);
                if (ext_ack) begin
                    bufWrEn = 1'b1;
                    beat_d  = beat_q + IdxW'(1);
                    if (beat_q == LastBeat) begin
                        bufSetValid = 1'b1;
                        state_d     = HIT_RSP;
                    end
                end
            end

            PROG: begin
                prog_active = 1'b1;
                bufInval    = 1'b1;
                if (!prog_mode) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    storage_line_buffer #(
        .MEM_W      (MEM_W),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TagW),
        .IDX_W      (IdxW)
    ) u_line_buffer (
        .clk          (clk),
        .rst          (rst),
        .inval_i      (bufInval),
        .fill_start_i (bufFillStart),
        .fill_tag_i   (extTag),
        .wr_en_i      (bufWrEn),
        .wr_idx_i     (beat_q),
        .wr_data_i    (ext_rdata),
        .set_valid_i  (bufSetValid),
        .lookup_tag_i (extTag),
        .hit_o        (bufHit),
        .tag_o        (bufTag),
        .rd_idx_i     (off_q),
        .rd_data_o    (bufRdata)
    );

endmodule

// File: tb/tb_storage_router.sv
// Directed bench for storage_router with behavioural SRAM and QSPI models (QSPI acks 3 cycles after request).
// Table-driven single requests plus hand sequences for programming mode, async reset and back-to-back traffic.
module tb_storage_router;
    import storage_router_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [3:0]           req_be;
    logic                 rsp_valid;
    logic [31:0]          rsp_rdata;
    logic                 rsp_err;
    logic                 prog_mode;
    logic                 prog_active;
    logic                 sram_cen_n;
    logic                 sram_gwen_n;
    logic [3:0]           sram_wen_n;
    logic [SRAM_AW-1:0]   sram_addr;
    logic [31:0]          sram_d;
    logic [31:0]          sram_q;
    logic                 ext_req;
    logic [EXT_AW-1:0]    ext_addr;
    logic                 ext_ack;
    logic [31:0]          ext_rdata;

    int checks = 0;
    int errors = 0;
    int cenCount = 0;
    int reqCount = 0;
    int extCnt;
    logic [31:0] extLog [$];
    logic [31:0] sramMem [2048];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] expData;
        logic        expErr;
        int          expLat;
        int          expCen;
        int          expReq;
    } vec_t;

    vec_t vecs[15];

    storage_router dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_be      (req_be),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .prog_mode   (prog_mode),
        .prog_active (prog_active),
        .sram_cen_n  (sram_cen_n),
        .sram_gwen_n (sram_gwen_n),
        .sram_wen_n  (sram_wen_n),
        .sram_addr   (sram_addr),
        .sram_d      (sram_d),
        .sram_q      (sram_q),
        .ext_req     (ext_req),
        .ext_addr    (ext_addr),
        .ext_ack     (ext_ack),
        .ext_rdata   (ext_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM macro: byte-masked write, registered read one cycle after the access.
    initial begin
        for (int i = 0; i < 2048; i++) sramMem[i] = '0;
        sram_q = '0;
    end

    always @(posedge clk) begin
        if (!sram_cen_n) begin
            if (!sram_gwen_n) begin
                for (int b = 0; b < 4; b++) begin
                    if (!sram_wen_n[b]) sramMem[sram_addr][b*8 +: 8] = sram_d[b*8 +: 8];
                end
            end else begin
                sram_q <= sramMem[sram_addr];
            end
        end
    end

    // QSPI: acks three cycles after a request is seen, returning the word index as data.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            extCnt    <= 0;
            ext_ack   <= 1'b0;
            ext_rdata <= '0;
        end else begin
            ext_ack <= 1'b0;
            if (ext_req && !ext_ack) begin
                if (extCnt == 2) begin
                    ext_ack   <= 1'b1;
                    ext_rdata <= 32'(ext_addr);
                    extCnt    <= 0;
                    extLog.push_back(32'(ext_addr));
                end else begin
                    extCnt <= extCnt + 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!sram_cen_n) cenCount++;
        if (ext_req) reqCount++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lineBase(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a - 32'h0001_0000) >> BYTE_OFF_W;
        return (idx >> LINE_OFF_W) << LINE_OFF_W;
    endfunction

    task automatic driveReq(input logic wr, input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
    endtask

    // Scrambles the request bus after acceptance so any failure to latch shows up.
    task automatic dropReq();
        req_valid = 1'b0;
        req_write = 1'b1;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = $urandom;
        req_be    = 4'hF;
    endtask

    task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, output logic [31:0] rdata, output logic err,
                                 output int lat);
        int waitCyc;
        lat   = 0;
        rdata = '0;
        err   = 1'b0;
        @(negedge clk);
        driveReq(wr, addr, wdata, be);
        waitCyc = 0;
        while (!req_ready && waitCyc < 50) begin
            @(negedge clk);
            waitCyc++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 32'(waitCyc), 32'd0);
            dropReq();
            lat = -1;
            return;
        end
        @(posedge clk);
        #1;
        dropReq();
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat   = c;
                rdata = rsp_rdata;
                err   = rsp_err;
            end
        end
        if (lat == 0) lat = -1;
    endtask

    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          cen0;
    int          req0;
    int          waitCyc;
    logic [31:0] b2bAddr [8];
    logic [31:0] b2bExp [8];
    logic [31:0] expLog [8];

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'b0101, 32'h0000_0000, 1'b0, 1,  1, 0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'hF,    32'h00AD_00EF, 1'b0, 1,  1, 0};
        vecs[2]  = '{1'b1, 32'h0000_0014, 32'h12345678, 4'hF,    32'h0000_0000, 1'b0, 1,  1, 0};
        vecs[3]  = '{1'b0, 32'h0000_0014, 32'h0,        4'hF,    32'h1234_5678, 1'b0, 1,  1, 0};
        vecs[4]  = '{1'b1, 32'h0000_1FFC, 32'hABCDEF01, 4'b1000, 32'h0000_0000, 1'b0, 1,  1, 0};
        vecs[5]  = '{1'b0, 32'h0000_1FFC, 32'h0,        4'hF,    32'hAB00_0000, 1'b0, 1,  1, 0};
        vecs[6]  = '{1'b0, 32'h0000_2000, 32'h0,        4'hF,    32'h0000_0000, 1'b1, 1,  0, 0};
        vecs[7]  = '{1'b1, 32'h0001_0000, 32'h55AA55AA, 4'hF,    32'h0000_0000, 1'b1, 1,  0, 0};
        vecs[8]  = '{1'b0, 32'h0000_9000, 32'h0,        4'hF,    32'h0000_0000, 1'b1, 1,  0, 0};
        vecs[9]  = '{1'b0, 32'h0005_0000, 32'h0,        4'hF,    32'h0000_0000, 1'b1, 1,  0, 0};
        vecs[10] = '{1'b0, 32'h0000_FFFC, 32'h0,        4'hF,    32'h0000_0000, 1'b1, 1,  0, 0};
        vecs[11] = '{1'b0, 32'h0004_FFFC, 32'h0,        4'hF,    32'h0000_FFFF, 1'b0, 17, 0, 16};
        vecs[12] = '{1'b0, 32'h0004_FFF0, 32'h0,        4'hF,    32'h0000_FFFC, 1'b0, 1,  0, 0};
        vecs[13] = '{1'b0, 32'h0001_0024, 32'h0,        4'hF,    32'h0000_0009, 1'b0, 17, 0, 16};
        vecs[14] = '{1'b0, 32'h0001_0028, 32'h0,        4'hF,    32'h0000_000A, 1'b0, 1,  0, 0};

        rst       = 1'b0;
        prog_mode = 1'b0;
        driveReq(1'b1, 32'h0000_0010, 32'hCAFEF00D, 4'hF);

        #12;
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp", {rsp_valid, rsp_err, prog_active, ext_req}, 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_ext_addr", 32'(ext_addr), 32'd0);
        checkOutput("rst_sram_ctl", {sram_cen_n, sram_gwen_n, sram_wen_n}, 32'h3F);
        checkOutput("rst_sram_addr", 32'(sram_addr), 32'd0);
        checkOutput("rst_sram_d", sram_d, 32'd0);
        dropReq();
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            cen0 = cenCount;
            req0 = reqCount;
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be, rdata, err, lat);
            $display("[TB] vector %0d addr=%h lat=%0d", i, vecs[i].addr, lat);
            checkOutput($sformatf("v%0d_rdata", i), rdata, vecs[i].expData);
            checkOutput($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].expErr));
            checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
            checkOutput($sformatf("v%0d_cen_cycles", i), 32'(cenCount - cen0), 32'(vecs[i].expCen));
            checkOutput($sformatf("v%0d_ext_req_cycles", i), 32'(reqCount - req0), 32'(vecs[i].expReq));
            @(negedge clk);
            checkOutput($sformatf("v%0d_pulse_width", i), 32'(rsp_valid), 32'd0);
        end

        for (int i = 0; i < 4; i++) begin
            expLog[i]     = lineBase(32'h0004_FFFC) + 32'(i);
            expLog[i + 4] = lineBase(32'h0001_0024) + 32'(i);
        end
        checkOutput("ext_log_size", 32'(extLog.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("ext_addr_beat%0d", i), (i < extLog.size()) ? extLog[i] : 32'hFFFF_FFFF, expLog[i]);
        end

        // Programming mode raised mid-fill: the fill must finish before the lockout begins.
        @(negedge clk);
        driveReq(1'b0, 32'h0001_0040, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        dropReq();
        repeat (3) @(negedge clk);
        prog_mode = 1'b1;
        lat = 0;
        for (int c = 0; c < 40 && lat == 0; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = 1;
                checkOutput("prog_fill_rdata", rsp_rdata, 32'd16);
                checkOutput("prog_fill_err", 32'(rsp_err), 32'd0);
            end
        end
        checkOutput("prog_fill_responded", 32'(lat), 32'd1);
        waitCyc = 0;
        while (!prog_active && waitCyc < 5) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("prog_active", 32'(prog_active), 32'd1);
        checkOutput("prog_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        prog_mode = 1'b0;
        req0 = reqCount;
        applyStimulus(1'b0, 32'h0001_0044, 32'h0, 4'hF, rdata, err, lat);
        checkOutput("prog_refetch_rdata", rdata, 32'd17);
        checkOutput("prog_refetch_latency", 32'(lat), 32'd17);
        checkOutput("prog_refetch_req_cycles", 32'(reqCount - req0), 32'd16);
        checkOutput("prog_active_cleared", 32'(prog_active), 32'd0);

        // Async reset between two acks of a fill.
        @(negedge clk);
        driveReq(1'b0, 32'h0001_0080, 32'h0, 4'hF);
        @(posedge clk);
        #1;
        dropReq();
        waitCyc = 0;
        while (!ext_ack && waitCyc < 20) begin
            @(negedge clk);
            waitCyc++;
        end
        checkOutput("rstfill_first_ack", 32'(ext_ack), 32'd1);
        @(posedge clk);
        #3;
        checkOutput("rstfill_req_before", 32'(ext_req), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("rstfill_ext_req_drop", 32'(ext_req), 32'd0);
        checkOutput("rstfill_ext_addr", 32'(ext_addr), 32'd0);
        checkOutput("rstfill_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        req0 = reqCount;
        applyStimulus(1'b0, 32'h0001_0080, 32'h0, 4'hF, rdata, err, lat);
        checkOutput("rstfill_refill_rdata", rdata, 32'd32);
        checkOutput("rstfill_refill_latency", 32'(lat), 32'd17);
        checkOutput("rstfill_refill_req_cycles", 32'(reqCount - req0), 32'd16);

        // Back-to-back alternating SRAM / buffer-hit reads with req_valid held high.
        b2bAddr = '{32'h10, 32'h1_0080, 32'h14, 32'h1_0084, 32'h10, 32'h1_0088, 32'h14, 32'h1_008C};
        b2bExp  = '{32'h00AD_00EF, 32'd32, 32'h1234_5678, 32'd33, 32'h00AD_00EF, 32'd34, 32'h1234_5678, 32'd35};
        begin
            int issued;
            int got;
            logic prevRsp;
            issued  = 0;
            got     = 0;
            prevRsp = 1'b0;
            req0    = reqCount;
            @(posedge clk);
            #1;
            driveReq(1'b0, b2bAddr[0], 32'h0, 4'hF);
            for (int cyc = 0; cyc < 64 && got < 8; cyc++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    checkOutput($sformatf("b2b%0d_prev_low", got), 32'(prevRsp), 32'd0);
                    checkOutput($sformatf("b2b%0d_rsp_cycle", got), 32'(cyc), 32'(2 * got + 1));
                    checkOutput($sformatf("b2b%0d_rdata", got), rsp_rdata, b2bExp[got]);
                    checkOutput($sformatf("b2b%0d_err", got), 32'(rsp_err), 32'd0);
                    got++;
                end
                prevRsp = rsp_valid;
                if (req_ready && issued < 8) begin
                    checkOutput($sformatf("b2b%0d_accept_cycle", issued), 32'(cyc), 32'(2 * issued));
                    @(posedge clk);
                    #1;
                    issued++;
                    if (issued < 8) driveReq(1'b0, b2bAddr[issued], 32'h0, 4'hF);
                    else dropReq();
                end
            end
            checkOutput("b2b_responses", 32'(got), 32'd8);
            checkOutput("b2b_no_ext_req", 32'(reqCount - req0), 32'd0);
            @(negedge clk);
            checkOutput("b2b_last_pulse_width", 32'(rsp_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
